// File: rtl/sync_down_counter.sv
// Prescaled synchronous down counter with parallel load, optional auto-reload and terminal-count pulse.
// Latency: q/tc registered, one cycle after the deciding edge; zero is combinational from q.
// Backpressure: none; en freezes prescaler and count, so no ticks are lost or added.
module sync_down_counter #(
    parameter int WIDTH       = 4,
    parameter int DIV         = 4,
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             zero,
    output logic             tc
);

    localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(DIV - 1);

    logic [PRE_W-1:0] pre;
    logic [WIDTH-1:0] reload;
    logic             tick;

    // With DIV=1 pre never leaves 0, so tick degenerates to en.
    assign tick = en && (pre == PRE_MAX);
    assign zero = (q == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            q      <= '0;
            pre    <= '0;
            reload <= '0;
            tc     <= 1'b0;
        end else if (load) begin
            q      <= load_val;
            reload <= load_val;
            pre    <= '0;
            tc     <= 1'b0;
        end else if (tick) begin
            pre <= '0;
            if (q != '0) begin
                q  <= q - 1'b1;
                tc <= 1'b0;
            end else begin
                q  <= AUTO_RELOAD ? reload : '1;
                tc <= 1'b1;
            end
        end else if (en) begin
            pre <= pre + 1'b1;
            tc  <= 1'b0;
        end else begin
            tc <= 1'b0;
        end
    end

endmodule

// File: doc/sync_down_counter.md
# sync_down_counter

Synchronous, fully clocked down counter for the Lab4 counter family: the counting-down counterpart to the ripple up counter. All flops share one clock. A clock-enable prescaler replaces the derived divided clock. The block supports parallel load, optional auto-reload and a one-cycle terminal-count pulse, so it can serve as a programmable timer or event divider.

## Interface
- `WIDTH`, 4: counter width in bits.
- `DIV`, 4: prescaler ratio; one count step per `DIV` enabled clocks (legal 1..65535).
- `AUTO_RELOAD`, 0: 0 = wrap from 0 to all-ones; 1 = wrap from 0 to the last loaded value.

Ports:
- `clk` in 1: system clock, rising edge.
- `reset` in 1: synchronous, active-high reset.
- `en` in 1: count enable; gates both the prescaler and the counter.
- `load` in 1: synchronous parallel load.
- `load_val` in WIDTH: value taken on `load`.
- `q` out WIDTH: current count (registered).
- `zero` out 1: combinational, equals `q == 0`.
- `tc` out 1: registered terminal-count pulse, high for one cycle per wrap.

## Operation
- Internal state: `pre` (prescaler, ceil(log2(DIV)) bits, minimum 1), `q`, `reload` (WIDTH), `tc`.
- `tick` = `en && (pre == DIV-1)`; with `DIV`=1, `tick` = `en`.
- Priority per rising edge, highest first:
  - `reset`: `q`=0, `pre`=0, `reload`=0, `tc`=0.
  - `load`: `q`=`load_val`, `reload`=`load_val`, `pre`=0, `tc`=0. `en` is ignored that cycle.
  - `tick` with `q`≠0: `q`=`q`-1, `pre`=0, `tc`=0.
  - `tick` with `q`==0: `q`=`reload` if `AUTO_RELOAD` else all-ones (2^WIDTH-1), `pre`=0, `tc`=1.
  - `en` without `tick`: `pre`=`pre`+1, `q` held, `tc`=0.
  - `en`=0: `pre`, `q` and `reload` held, `tc`=0.
- Arithmetic: modulo 2^WIDTH, unsigned. There is no down-count past 0 other than the defined wrap.
- `AUTO_RELOAD`=1 with `reload`=0: the wrap loads 0. `q` stays 0 and `tc` pulses on every tick, acting as a pure tick divider.
- `load` and `reset` asserted together: reset wins.
- Deasserting `en` mid-prescale freezes `pre`. Counting resumes where it stopped, with no lost or extra ticks.

## Timing
- Reset values: `q`=0, `zero`=1, `tc`=0.
- Load latency: `q` shows `load_val` one cycle after the `load` edge.
- From a load, with `en` continuously high, the first decrement occurs on the `DIV`th following rising edge. Each later step follows every `DIV` enabled edges.
- `tc` is high during exactly the cycle in which `q` first shows the wrapped value. It never stays high for two consecutive cycles unless `DIV`=1 and `q` wraps on consecutive ticks (the `AUTO_RELOAD`, `reload`=0 case).
- `zero` follows `q` combinationally with no added latency.
- Reset mid-count takes effect at the next edge, regardless of `en`, `load` or `pre`.

## Test plan
- Reset then free-run (WIDTH=4, DIV=4, AUTO_RELOAD=0, `en`=1): `q`=0 and `zero`=1 after reset. 4 edges later `q`=15 with `tc`=1 for one cycle. Then `q` steps 14, 13, … every 4 cycles.
- Load and count down (DIV=4, `load_val`=3): `q`=3 next cycle. Then 2, 1, 0 at +4, +8, +12 edges. `zero`=1 at 0. At +16, `q`=15 and `tc` pulses.
- Auto-reload (AUTO_RELOAD=1, DIV=1, `load_val`=2): `q` sequence 2, 1, 0, 2, 1, 0…. `tc`=1 exactly in cycles where `q` returns to 2, i.e. every third cycle.
- Enable gating (DIV=4): drop `en` for 5 cycles after 2 enabled cycles post-load. `q` and `pre` are frozen. The decrement lands exactly 2 enabled cycles after `en` returns.
- Priority: `load`=1 with `load_val`=9 on a tick-due wrap cycle at `q`=0 → `q`=9 and `tc`=0. `reset` and `load` together → `q`=0.
- Reset mid-count (`q`=7, `pre`=2, `en`=1): `q`=0, `tc`=0 next cycle. The next decrement or wrap happens after a full `DIV` enabled edges.
